// File: rtl/sd_to_sdram_dma.sv
// SD block reader to SDRAM copy engine: packs bytes into 16-bit
// little-endian words and writes them to consecutive word addresses.
module sd_to_sdram_dma #(
    parameter int ADDR_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           sd_first_block,
    input  logic [15:0]           block_count,
    input  logic [ADDR_WIDTH-1:0] sdram_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  blk_req,
    output logic [31:0]           blk_addr,
    input  logic                  blk_ack,
    input  logic                  blk_err,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [15:0]           mem_wr_data,
    input  logic                  mem_wr_ack
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, REQ, RECV, DRAIN, ABORT
    } state_t;

    state_t state, state_nx;

    logic [31:0]           first_q;
    logic [15:0]           cnt_q;
    logic [15:0]           idx_q;
    logic [8:0]            byte_cnt;
    logic [7:0]            low_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           fifo [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic                  pend_q;
    logic                  done_q;
    logic                  err_q;

    logic fifo_empty, fifo_full;
    logic xfer, push, pop;
    logic last_byte, last_block;
    logic drained, abort_fin;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));

    // In ABORT only the write already on the bus may finish.
    assign mem_wr_req  = (state == ABORT) ? pend_q : !fifo_empty;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = mem_wr_req ? fifo[rd_ptr] : 16'h0;
    assign pop         = mem_wr_req && mem_wr_ack;

    assign byte_ready = (state == RECV) && !blk_err &&
                        (!fifo_full || !byte_cnt[0]);
    assign xfer       = byte_valid && byte_ready;
    assign push       = xfer && byte_cnt[0];
    assign last_byte  = (byte_cnt == 9'd511);
    assign last_block = ((idx_q + 16'd1) == cnt_q);

    assign blk_req  = (state == REQ);
    assign blk_addr = first_q + {16'h0, idx_q};
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign err      = err_q;

    assign drained = fifo_empty ||
                     ((count == (PW+1)'(1)) && pop);
    assign abort_fin = !pend_q || mem_wr_ack;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (block_count == 16'h0) ? DRAIN : REQ;
            end
            REQ: begin
                if (blk_err)
                    state_nx = ABORT;
                else if (blk_ack)
                    state_nx = RECV;
            end
            RECV: begin
                if (blk_err)
                    state_nx = ABORT;
                else if (xfer && last_byte)
                    state_nx = last_block ? DRAIN : REQ;
            end
            DRAIN: begin
                if (drained)
                    state_nx = IDLE;
            end
            ABORT: begin
                if (abort_fin)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= {byte_data, low_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            first_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            byte_cnt <= '0;
            low_q    <= '0;
            addr_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            if (state == IDLE && start) begin
                first_q  <= sd_first_block;
                cnt_q    <= block_count;
                idx_q    <= '0;
                byte_cnt <= '0;
                addr_q   <= sdram_base;
                err_q    <= 1'b0;
            end
            if (xfer) begin
                byte_cnt <= byte_cnt + 9'd1;
                if (!byte_cnt[0])
                    low_q <= byte_data;
                if (last_byte)
                    idx_q <= idx_q + 16'd1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (state_nx == ABORT && state != ABORT)
                pend_q <= mem_wr_req && !mem_wr_ack;
            if (state == DRAIN && drained)
                done_q <= 1'b1;
            // Flush whatever is still queued once the bus write is settled.
            if (state == ABORT && abort_fin) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
                pend_q <= 1'b0;
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sd_to_sdram_dma.sv
// Randomised scoreboard bench for sd_to_sdram_dma with SD reader
// and SDRAM controller models.
module tb_sd_to_sdram_dma;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] sd_first_block;
    logic [15:0] block_count;
    logic [23:0] sdram_base;
    logic        busy, done, err;
    logic        blk_req;
    logic [31:0] blk_addr;
    logic        blk_ack, blk_err;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr_req;
    logic [23:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_ack;

    sd_to_sdram_dma #(.ADDR_WIDTH(24), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sd_first_block(sd_first_block), .block_count(block_count),
        .sdram_base(sdram_base), .busy(busy), .done(done), .err(err),
        .blk_req(blk_req), .blk_addr(blk_addr), .blk_ack(blk_ack),
        .blk_err(blk_err), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_addr [$];
    logic [15:0] exp_data [$];
    logic [31:0] blkq [$];

    logic [7:0] salt;
    int ack_delay = 0;
    int err_at = -1;
    int words_pushed = 0;
    int writes_done = 0;
    int exp_total = -1;
    int err_queued = 0;
    int done_cnt = 0;
    int rd_phase = 0;
    int rd_blk = 0;
    int rd_i = 0;
    int rd_bytes = 0;
    int rd_wait = 0;
    int sd_wait = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    function automatic logic [7:0] byte_of(int b, int i);
        return 8'(i + b * 37 + int'(salt));
    endfunction

    // SD reader model: acks requests, streams 512 bytes, injects errors.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_phase   = 0;
            blk_ack    = 1'b0;
            byte_valid = 1'b0;
            blk_err    = 1'b0;
        end else begin
            blk_ack    = 1'b0;
            blk_err    = 1'b0;
            byte_valid = 1'b0;
            if (rd_phase == 0 && blk_req) begin
                if (rd_wait > 0) begin
                    rd_wait--;
                end else begin
                    blk_ack = 1'b1;
                    if (blkq.size() == 0)
                        bad("blk_req_unexpected");
                    else
                        chk("blk_addr", blk_addr, blkq.pop_front());
                    rd_phase = 1;
                    rd_i = 0;
                    rd_wait = $urandom_range(0, 3);
                end
            end else if (rd_phase == 1) begin
                if (err_at >= 0 && rd_bytes == err_at) begin
                    blk_err = 1'b1;
                    rd_phase = 2;
                end else begin
                    chk("byte_ready", byte_ready,
                        (words_pushed - writes_done < 8) ||
                        (rd_i % 2 == 0));
                    if ($urandom_range(0, 7) != 0) begin
                        byte_valid = 1'b1;
                        byte_data = byte_of(rd_blk, rd_i);
                        if (byte_ready) begin
                            rd_bytes++;
                            if (rd_i % 2 == 1)
                                words_pushed++;
                            rd_i++;
                            if (rd_i == 512) begin
                                rd_phase = 0;
                                rd_blk++;
                            end
                        end
                    end
                end
            end
        end
    end

    // SDRAM model and write monitor.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            mem_wr_ack = 1'b0;
            sd_wait = 0;
        end else begin
            if (blk_err) begin
                err_queued = words_pushed - writes_done;
                exp_total = writes_done + ((err_queued > 0) ? 1 : 0);
            end
            if (mem_wr_req) begin
                if (sd_wait >= ack_delay) begin
                    mem_wr_ack = 1'b1;
                    sd_wait = 0;
                    writes_done++;
                    if (exp_addr.size() == 0) begin
                        bad("write_unexpected");
                    end else begin
                        chk("wr_addr", mem_wr_addr, exp_addr.pop_front());
                        chk("wr_data", mem_wr_data, exp_data.pop_front());
                    end
                end else begin
                    mem_wr_ack = 1'b0;
                    sd_wait++;
                end
            end else begin
                mem_wr_ack = (ack_delay == 0);
                sd_wait = 0;
            end
        end
    end

    always @(negedge clk)
        if (rst_n && done)
            done_cnt++;

    task automatic check_reset_outputs(string nm);
        chk({nm, "_ctrl"},
            {busy, done, err, blk_req, byte_ready, mem_wr_req}, 0);
        chk({nm, "_wr"}, {mem_wr_addr, mem_wr_data}, 0);
        chk({nm, "_blk_addr"}, blk_addr, 0);
    endtask

    task automatic run(input logic [31:0] first, input int cnt,
                       input logic [23:0] base, input logic [7:0] slt,
                       input int dly, input int eat,
                       input int poke_at, input int reset_at);
        int d0;
        int c_got;
        logic got;
        logic exp_err;
        salt = slt;
        ack_delay = dly;
        err_at = eat;
        words_pushed = 0;
        writes_done = 0;
        rd_bytes = 0;
        rd_blk = 0;
        rd_phase = 0;
        rd_wait = $urandom_range(0, 3);
        exp_total = -1;
        err_queued = 0;
        exp_err = (eat >= 0);
        exp_addr.delete();
        exp_data.delete();
        blkq.delete();
        for (int b = 0; b < cnt; b++) begin
            blkq.push_back(first + 32'(b));
            for (int k = 0; k < 256; k++) begin
                exp_addr.push_back(24'(base + 24'(b * 256 + k)));
                exp_data.push_back({byte_of(b, 2 * k + 1),
                                    byte_of(b, 2 * k)});
            end
        end
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        sd_first_block = first;
        block_count = 16'(cnt);
        sdram_base = base;
        @(negedge clk);
        start = 1'b0;
        sd_first_block = $urandom;
        block_count = 16'($urandom);
        sdram_base = 24'($urandom);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
        chk("blk_req_after_start", blk_req, cnt != 0);
        got = 1'b0;
        c_got = -1;
        for (int c = 0; c < 20000 && !got; c++) begin
            start = (c == poke_at);
            if (c == reset_at) begin
                #3 rst_n = 1'b0;
                #1 check_reset_outputs("reset_mid");
                repeat (3) @(negedge clk);
                exp_addr.delete();
                exp_data.delete();
                blkq.delete();
                words_pushed = 0;
                writes_done = 0;
                #2 rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                c_got = c;
                chk("done_err", err, exp_err);
            end
        end
        start = 1'b0;
        if (!got) begin
            bad("done_timeout");
            return;
        end
        if (cnt == 0)
            chk("zero_done_latency", c_got, 0);
        if (exp_err) begin
            chk("abort_write_count", writes_done, exp_total);
            chk("abort_queue_ge2", err_queued >= 2, 1);
        end else begin
            chk("write_count", writes_done, cnt * 256);
            chk("exp_left", exp_addr.size(), 0);
            chk("blk_left", blkq.size(), 0);
        end
        repeat (5) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);
        chk("idle_after_done", busy, 0);
        chk("err_held", err, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sd_first_block = '0;
        block_count = '0;
        sdram_base = '0;
        blk_ack = 1'b0;
        blk_err = 1'b0;
        byte_valid = 1'b0;
        byte_data = '0;
        mem_wr_ack = 1'b0;
        salt = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        run(32'd5, 1, 24'h000100, 8'h00, 0, -1, -1, -1);
        run($urandom, 0, 24'($urandom), 8'($urandom), 0, -1, -1, -1);
        run(32'hFFFF_FFFF, 2, 24'($urandom), 8'($urandom),
            10, -1, -1, -1);
        run($urandom, 2, 24'($urandom), 8'($urandom),
            10, 101, -1, -1);
        run($urandom, 1, 24'hFFFF80, 8'($urandom), 2, -1, 200, -1);
        run($urandom, 2, 24'($urandom), 8'($urandom), 1, -1, -1, 400);
        run($urandom, 1, 24'($urandom), 8'($urandom),
            $urandom_range(0, 3), -1, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
